// File: rtl/tick_debounce_pkg.sv
// Shared definitions for the button debouncer: width helper and FSM state encoding.
package tick_debounce_pkg;

    // Bits needed to hold values 0..value-1; also used by the clock divider.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem != 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        StReleased = 2'd0,
        StPressChk = 2'd1,
        StHeld     = 2'd2,
        StRelChk   = 2'd3
    } state_e;

endpackage

// File: rtl/tick_debounce_btn_sync.sv
// Two-flop synchronizer for asynchronous pins, with a parameterised reset value.
module tick_debounce_btn_sync #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iPin,
    output logic [WIDTH-1:0] oSync
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_meta <= RST_VAL;
            oSync  <= RST_VAL;
        end else begin
            r_meta <= iPin;
            oSync  <= r_meta;
        end
    end

endmodule

// File: rtl/tick_debounce.sv
// Tick-paced push-button debouncer emitting press, release and long-press pulses.
module tick_debounce
    import tick_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS   = 4,
    parameter int unsigned LONG_TICKS     = 16,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iTick,
    input  logic iBtn,
    output logic oLevel,
    output logic oPress,
    output logic oRelease,
    output logic oLongPress
);

    localparam int unsigned     DW       = clog2(STABLE_TICKS);
    localparam int unsigned     HW       = clog2(LONG_TICKS + 1);
    localparam logic [DW-1:0]   DcntLast = DW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0]   HcntMax  = HW'(LONG_TICKS);

    logic          w_sync;
    logic          w_act;
    logic [HW-1:0] w_hcnt_inc;

    state_e        r_state;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    logic          r_long_fired;

    tick_debounce_btn_sync #(
        .WIDTH   (1),
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_btn_sync (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iPin   (iBtn),
        .oSync  (w_sync)
    );

    assign w_act      = w_sync ^ BTN_ACTIVE_LOW;
    assign w_hcnt_inc = (r_hcnt == HcntMax) ? r_hcnt : r_hcnt + HW'(1);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state      <= StReleased;
            r_dcnt       <= '0;
            r_hcnt       <= '0;
            r_long_fired <= 1'b0;
            oLevel       <= 1'b0;
            oPress       <= 1'b0;
            oRelease     <= 1'b0;
            oLongPress   <= 1'b0;
        end else begin
            oPress     <= 1'b0;
            oRelease   <= 1'b0;
            oLongPress <= 1'b0;
            if (iTick) begin
                unique case (r_state)
                    StReleased: begin
                        if (w_act) begin
                            r_state <= StPressChk;
                            r_dcnt  <= DW'(1);
                        end
                    end
                    StPressChk: begin
                        if (!w_act) begin
                            r_state <= StReleased;
                            r_dcnt  <= '0;
                        end else if (r_dcnt == DcntLast) begin
                            r_state <= StHeld;
                            r_dcnt  <= '0;
                            r_hcnt  <= HW'(1);
                            oLevel  <= 1'b1;
                            oPress  <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + DW'(1);
                        end
                    end
                    StHeld: begin
                        if (w_act) begin
                            r_hcnt <= w_hcnt_inc;
                            if (w_hcnt_inc == HcntMax && !r_long_fired) begin
                                oLongPress   <= 1'b1;
                                r_long_fired <= 1'b1;
                            end
                        end else begin
                            r_state <= StRelChk;
                            r_dcnt  <= DW'(1);
                        end
                    end
                    StRelChk: begin
                        // hcnt stays frozen here so a bounce resumes the long-press count.
                        if (w_act) begin
                            r_state <= StHeld;
                            r_dcnt  <= '0;
                        end else if (r_dcnt == DcntLast) begin
                            r_state      <= StReleased;
                            r_dcnt       <= '0;
                            r_hcnt       <= '0;
                            r_long_fired <= 1'b0;
                            oLevel       <= 1'b0;
                            oRelease     <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + DW'(1);
                        end
                    end
                    default: begin
                        r_state <= StReleased;
                    end
                endcase
            end
        end
    end

endmodule
